io_response_interface: RTL and testbench

IO_RESPONSE_INTERFACE -- requirements
Module: io_response_interface

---
 rtl/io_response_interface_if.sv | 27 ++
 rtl/io_response_interface.sv | 116 +++++++++++
 tb/tb_io_response_interface.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_response_interface_if.sv
// rtl/io_response_interface_if.sv - response-in / writeback-out handshake bundle
interface io_response_if #(
   parameter int DATABITWIDTH    = 16,
   parameter int PORTBYTEWIDTH   = 8,
   parameter int REGADDRBITWIDTH = 4
);
   logic                       ResponseInACK;
   logic                       ResponseInREQ;
   logic [3:0]                 MinorOpcodeIn;
   logic [REGADDRBITWIDTH-1:0] RegisterDestIn;
   logic [DATABITWIDTH-1:0]    DataAddrIn;
   logic [PORTBYTEWIDTH*8-1:0] DataIn;
   logic                       WritebackACK;
   logic                       WritebackREQ;
   logic [REGADDRBITWIDTH-1:0] WritebackDest;
   logic [DATABITWIDTH-1:0]    WritebackData;

   modport slave (
      input  ResponseInACK, MinorOpcodeIn, RegisterDestIn, DataAddrIn, DataIn, WritebackREQ,
      output ResponseInREQ, WritebackACK, WritebackDest, WritebackData
   );

   modport master (
      output ResponseInACK, MinorOpcodeIn, RegisterDestIn, DataAddrIn, DataIn, WritebackREQ,
      input  ResponseInREQ, WritebackACK, WritebackDest, WritebackData
   );
endinterface

// File: rtl/io_response_interface.sv
// rtl/io_response_interface.sv - formats IO port read responses into register writebacks
module io_response_interface #(
   parameter int DATABITWIDTH    = 16,
   parameter int PORTBYTEWIDTH   = 8,
   parameter int REGADDRBITWIDTH = 4,
   parameter int BUFFERCOUNT     = (PORTBYTEWIDTH*8 <= DATABITWIDTH) ? 1 : PORTBYTEWIDTH*8/DATABITWIDTH
) (
   input logic         clk,
   input logic         async_rst,
   input logic         clk_en,
   io_response_if.slave bus
);
   localparam int DW      = DATABITWIDTH;
   localparam int PW      = PORTBYTEWIDTH*8;
   localparam int RW      = REGADDRBITWIDTH;
   localparam int BYTES   = DW/8;
   localparam int OFFBITS = $clog2(BYTES);
   localparam int IDXW    = (BUFFERCOUNT > 1) ? $clog2(BUFFERCOUNT) : 1;
   localparam int PADW    = BUFFERCOUNT*DW;

   typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] beat_q, beat_d;
   logic [PW-1:0]   data_q;
   logic [3:0]      op_q;
   logic [RW-1:0]   dest_q;
   logic [DW-1:0]   addr_q;

   logic            final_beat;
   logic            accept;
   logic            wb_fire;
   logic            wb_ack;

   assign wb_ack     = (state_q != IDLE);
   assign final_beat = (state_q == SINGLE) ||
                       ((state_q == BURST) && (beat_q == IDXW'(BUFFERCOUNT-1)));
   // Final beat draining frees the slot, so a new response may land on the same edge.
   assign bus.ResponseInREQ = (state_q == IDLE) || (final_beat && bus.WritebackREQ);
   assign accept     = bus.ResponseInACK && bus.ResponseInREQ && clk_en;
   assign wb_fire    = wb_ack && bus.WritebackREQ && clk_en;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      if ((state_q == IDLE) || (wb_fire && final_beat)) begin
         state_d = IDLE;
         beat_d  = '0;
         if (accept) begin
            state_d = ((bus.MinorOpcodeIn[3:2] == 2'b11) && (BUFFERCOUNT > 1)) ? BURST : SINGLE;
         end
      end else if (wb_fire) begin
         beat_d = beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         data_q <= '0;
         op_q   <= '0;
         dest_q <= '0;
         addr_q <= '0;
      end else if (accept) begin
         data_q <= bus.DataIn;
         op_q   <= bus.MinorOpcodeIn;
         dest_q <= bus.RegisterDestIn;
         addr_q <= bus.DataAddrIn;
      end
   end

   logic [PADW-1:0] padded;
   logic [IDXW-1:0] word_idx;
   logic [IDXW-1:0] sel;
   logic [DW-1:0]   word;
   logic [DW-1:0]   shift_bits;
   logic [DW-1:0]   shifted;
   logic [DW-1:0]   keep;
   logic [7:0]      nbits;
   logic            sign;
   logic [DW-1:0]   formatted;
   logic [DW-1:0]   result;

   always_comb begin
      padded     = PADW'(data_q);
      word_idx   = IDXW'(addr_q >> OFFBITS) & IDXW'(BUFFERCOUNT-1);
      sel        = (state_q == BURST) ? beat_q : word_idx;
      word       = padded[sel*DW +: DW];
      shift_bits = (addr_q & DW'(BYTES-1)) << 3;
      shifted    = word >> shift_bits;
      nbits      = 8'd8 << op_q[1:0];
      if (nbits >= 8'(DW)) begin
         keep = '1;
      end else begin
         keep = (DW'(1) << nbits) - DW'(1);
      end
      // Top kept bit is the sign; only meaningful when the load is narrower than a word.
      sign      = op_q[2] && (|(shifted & keep & ~(keep >> 1))) && (nbits < 8'(DW));
      formatted = (shifted & keep) | (sign ? ~keep : '0);
      result    = ((state_q == BURST) || op_q[3]) ? word : formatted;
   end

   assign bus.WritebackACK  = wb_ack;
   assign bus.WritebackData = wb_ack ? result : '0;
   assign bus.WritebackDest = wb_ack ? (dest_q + RW'(beat_q)) : '0;

endmodule

// File: tb/tb_io_response_interface.sv
// tb/tb_io_response_interface.sv - scoreboard bench for io_response_interface
module tb_io_response_interface;
   localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;

   logic clk;
   logic async_rst;
   logic clk_en;

   io_response_if #(.DATABITWIDTH(16), .PORTBYTEWIDTH(8), .REGADDRBITWIDTH(4)) bus ();

   io_response_interface #(
      .DATABITWIDTH(16), .PORTBYTEWIDTH(8), .REGADDRBITWIDTH(4)
   ) u_dut (
      .clk      (clk),
      .async_rst(async_rst),
      .clk_en   (clk_en),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  dest;
      logic [15:0] data;
      bit          last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   rand_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_exp(input logic [3:0] dest, input logic [15:0] data, input bit last);
      exp_t e;
      e.dest = dest; e.data = data; e.last = last;
      exp_q.push_back(e);
   endfunction

   // Reference: 16-bit words of a 64-bit beat, byte offset addr%2, word index (addr/2)%4.
   function automatic void model_push(input logic [3:0] op, input logic [3:0] dest,
                                      input logic [15:0] addr, input logic [63:0] data);
      int unsigned idx, off, nb, w, v, m;
      idx = (int'(addr) / 2) % 4;
      off = int'(addr) % 2;
      if (op[3:2] == 2'b11) begin
         for (int k = 0; k < 4; k++)
            push_exp(dest + 4'(k), 16'((data >> (16*k)) & 64'hFFFF), k == 3);
      end else begin
         w = 32'((data >> (16*idx)) & 64'hFFFF);
         if (op[3] == 1'b1) begin
            v = w;
         end else begin
            w  = w >> (8*off);
            nb = 8 << op[1:0];
            if (nb >= 16) begin
               v = w;
            end else begin
               m = (1 << nb) - 1;
               v = w & m;
               if (op[2] && (((w >> (nb-1)) & 1) == 1)) v = v | (~m & 32'hFFFF);
            end
         end
         push_exp(dest, 16'(v), 1'b1);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         bus.WritebackREQ = ($urandom % 4) != 0;
         clk_en           = ($urandom % 8) != 0;
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] dest, input logic [15:0] addr,
                       input logic [63:0] data, input bit use_model, output int waited);
      bit done;
      done = 0;
      waited = 0;
      bus.ResponseInACK  = 1'b1;
      bus.MinorOpcodeIn  = op;
      bus.RegisterDestIn = dest;
      bus.DataAddrIn     = addr;
      bus.DataIn         = data;
      while (!done && waited < 200) begin
         @(negedge clk);
         if (bus.ResponseInREQ && clk_en) begin
            if (use_model) model_push(op, dest, addr, data);
            done = 1;
         end else begin
            waited++;
         end
         tick();
      end
      if (!done) chk("accept_timeout", 64'(waited), 64'(0));
   endtask

   task automatic idle();
      bus.ResponseInACK = 1'b0;
   endtask

   // Monitor: scoreboard pops on every writeback handshake.
   logic        prev_hold = 0;
   logic [3:0]  prev_dest;
   logic [15:0] prev_data;

   always @(negedge clk) begin
      if (async_rst) begin
         prev_hold = 0;
      end else begin
         if (bus.WritebackACK) begin
            if (prev_hold) begin
               chk("hold_dest", 64'(bus.WritebackDest), 64'(prev_dest));
               chk("hold_data", 64'(bus.WritebackData), 64'(prev_data));
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_writeback", 64'(bus.WritebackData), 64'hDEAD_0000_0000_0000);
            end else begin
               chk("wb_dest", 64'(bus.WritebackDest), 64'(exp_q[0].dest));
               chk("wb_data", 64'(bus.WritebackData), 64'(exp_q[0].data));
               chk("resp_req_busy", 64'(bus.ResponseInREQ), 64'(exp_q[0].last && bus.WritebackREQ));
               if (bus.WritebackREQ && clk_en) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_data", 64'(bus.WritebackData), 64'(0));
            chk("idle_dest", 64'(bus.WritebackDest), 64'(0));
            chk("idle_req",  64'(bus.ResponseInREQ), 64'(1));
         end
         prev_hold = bus.WritebackACK && !(bus.WritebackREQ && clk_en);
         prev_dest = bus.WritebackDest;
         prev_data = bus.WritebackData;
      end
   end

   initial begin
      int w;
      async_rst = 1'b1;
      clk_en    = 1'b1;
      bus.ResponseInACK  = 1'b1;
      bus.MinorOpcodeIn  = 4'b1100;
      bus.RegisterDestIn = 4'h3;
      bus.DataAddrIn     = 16'h0;
      bus.DataIn         = D;
      bus.WritebackREQ   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",  64'(bus.ResponseInREQ), 64'(1));
      chk("rst_ack",  64'(bus.WritebackACK),  64'(0));
      chk("rst_data", 64'(bus.WritebackData), 64'(0));
      chk("rst_dest", 64'(bus.WritebackDest), 64'(0));
      idle();
      async_rst = 1'b0;
      tick();
      chk("rst_ignored_ack", 64'(bus.WritebackACK), 64'(0));

      bus.WritebackREQ = 1'b1;
      push_exp(4'h5, 16'hFF89, 1);
      send(4'b0100, 4'h5, 16'h0003, D, 0, w);
      idle();
      repeat (2) tick();

      push_exp(4'h2, 16'h4567, 1);
      send(4'b0001, 4'h2, 16'h0004, D, 0, w);
      push_exp(4'h7, 16'h89AB, 1);
      send(4'b1000, 4'h7, 16'h0002, D, 0, w);
      chk("b2b_no_bubble", 64'(w), 64'(0));
      idle();
      repeat (2) tick();

      push_exp(4'hE, 16'hCDEF, 0);
      push_exp(4'hF, 16'h89AB, 0);
      push_exp(4'h0, 16'h4567, 0);
      push_exp(4'h1, 16'h0123, 1);
      send(4'b1100, 4'hE, 16'h0000, D, 0, w);
      idle();
      repeat (5) tick();

      bus.WritebackREQ = 1'b0;
      push_exp(4'h3, 16'h0123, 1);
      send(4'b0010, 4'h3, 16'h0006, D, 0, w);
      idle();
      repeat (3) tick();
      bus.WritebackREQ = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) begin
         send(4'($urandom), 4'($urandom), 16'($urandom), {$urandom, $urandom}, 1, w);
         if (i > 0) chk("b2b_rand_no_bubble", 64'(w), 64'(0));
      end
      idle();
      repeat (6) tick();

      push_exp(4'hE, 16'hCDEF, 0);
      push_exp(4'hF, 16'h89AB, 0);
      send(4'b1100, 4'hE, 16'h0000, D, 0, w);
      idle();
      tick();
      #2 async_rst = 1'b1;
      #1;
      chk("midrst_ack",  64'(bus.WritebackACK),  64'(0));
      chk("midrst_req",  64'(bus.ResponseInREQ), 64'(1));
      chk("midrst_data", 64'(bus.WritebackData), 64'(0));
      exp_q.delete();
      tick();
      #2 async_rst = 1'b0;
      tick();
      push_exp(4'h9, 16'hCDEF, 0);
      push_exp(4'hA, 16'h89AB, 0);
      push_exp(4'hB, 16'h4567, 0);
      push_exp(4'hC, 16'h0123, 1);
      send(4'b1100, 4'h9, 16'h0000, D, 0, w);
      idle();
      repeat (6) tick();

      clk_en = 1'b0;
      bus.ResponseInACK  = 1'b1;
      bus.MinorOpcodeIn  = 4'b0000;
      bus.RegisterDestIn = 4'h6;
      bus.DataAddrIn     = 16'h0001;
      repeat (2) tick();
      chk("clken_no_accept", 64'(bus.WritebackACK), 64'(0));
      clk_en = 1'b1;
      send(4'b0000, 4'h6, 16'h0001, D, 1, w);
      idle();
      repeat (2) tick();

      bus.WritebackREQ = 1'b0;
      send(4'b1100, 4'h0, 16'h0000, D, 1, w);
      idle();
      clk_en = 1'b0;
      bus.WritebackREQ = 1'b1;
      repeat (2) tick();
      chk("clken_stall_dest", 64'(bus.WritebackDest), 64'(0));
      chk("clken_stall_data", 64'(bus.WritebackData), 64'h0000_0000_0000_CDEF);
      clk_en = 1'b1;
      repeat (6) tick();

      rand_mode = 1;
      for (int i = 0; i < 150; i++) begin
         send(4'($urandom), 4'($urandom), 16'($urandom), {$urandom, $urandom}, 1, w);
         if ($urandom % 3 == 0) begin
            idle();
            tick();
         end
      end
      idle();
      rand_mode = 0;
      clk_en = 1'b1;
      bus.WritebackREQ = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      tick();
      chk("drain_empty", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
